// File: rtl/replay_pkg.sv
// Shared types and constants for the stimulus replay checker.
// Operand field layout of the packed 12-bit vectors.
package replay_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam int OPND_W     = 4;
  localparam int W1_LSB     = 0;
  localparam int W2_LSB     = 4;
  localparam int W3_LSB     = 8;
  localparam int FIRST_ADDR = 1;

endpackage

// File: rtl/triple_out_compare.sv
// Compares the equation and netlist views against the behavioural view.
// A vector fails when either view disagrees with the reference.
module triple_out_compare #(
  parameter int OUT_W = 4
) (
  input  logic [OUT_W-1:0] out_ref,
  input  logic [OUT_W-1:0] out_eq,
  input  logic [OUT_W-1:0] out_net,
  output logic             fail
);

  assign fail = (out_eq != out_ref) || (out_net != out_ref);

endmodule

// File: rtl/vector_replay_checker.sv
// Replays packed stimulus vectors from memory onto w1/w2/w3 and
// counts vectors where the three design views disagree.
module vector_replay_checker
  import replay_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 32,
  parameter int OUT_W  = 4,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              global_reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_vectors,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_rd_valid,
  output logic [OPND_W-1:0] w1,
  output logic [OPND_W-1:0] w2,
  output logic [OPND_W-1:0] w3,
  input  logic [OUT_W-1:0]  out_ref,
  input  logic [OUT_W-1:0]  out_eq,
  input  logic [OUT_W-1:0]  out_net,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  mismatch_count,
  output logic [ADDR_W-1:0] first_fail_addr
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] count_q;
  logic [7:0]        settle_q;
  logic [OPND_W-1:0] w1_q;
  logic [OPND_W-1:0] w2_q;
  logic [OPND_W-1:0] w3_q;
  logic [CNT_W-1:0]  mis_q;
  logic [ADDR_W-1:0] ffa_q;
  logic              fail;
  logic              last;
  logic              accept;

  triple_out_compare #(
    .OUT_W(OUT_W)
  ) u_cmp (
    .out_ref(out_ref),
    .out_eq (out_eq),
    .out_net(out_net),
    .fail   (fail)
  );

  assign last   = (addr_q == count_q);
  assign accept = (state_q == S_IDLE) && start;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (num_vectors == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH:  state_d = S_WAIT;
      S_WAIT: begin
        if (mem_rd_valid) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = S_CHECK;
      end
      S_CHECK:  state_d = last ? S_DONE : S_FETCH;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (global_reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      count_q  <= '0;
      settle_q <= '0;
      w1_q     <= '0;
      w2_q     <= '0;
      w3_q     <= '0;
      mis_q    <= '0;
      ffa_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= ADDR_W'(FIRST_ADDR);
        count_q <= num_vectors;
        mis_q   <= '0;
        ffa_q   <= '0;
      end
      if (state_q == S_WAIT && mem_rd_valid) begin
        w1_q     <= mem_rd_data[W1_LSB +: OPND_W];
        w2_q     <= mem_rd_data[W2_LSB +: OPND_W];
        w3_q     <= mem_rd_data[W3_LSB +: OPND_W];
        settle_q <= '0;
      end
      if (state_q == S_SETTLE) begin
        settle_q <= settle_q + 8'd1;
      end
      if (state_q == S_CHECK) begin
        if (fail) begin
          if (mis_q != '1) mis_q <= mis_q + 1'b1;
          // count is zero only until the first failure of this replay
          if (mis_q == '0) ffa_q <= addr_q;
        end
        if (!last) addr_q <= addr_q + 1'b1;
      end
    end
  end

  assign mem_rd_en       = (state_q == S_FETCH);
  assign mem_addr        = addr_q;
  assign w1              = w1_q;
  assign w2              = w2_q;
  assign w3              = w3_q;
  assign busy            = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done            = (state_q == S_DONE);
  assign mismatch_count  = mis_q;
  assign first_fail_addr = ffa_q;

endmodule

// File: tb/tb_vector_replay_checker.sv
// Bench for vector_replay_checker: table vectors, corner sequences
// and randomized replays against a transaction-level model.
module tb_vector_replay_checker;

  localparam int S  = 2;
  localparam int CW = 2;

  logic        clk = 1'b0;
  logic        global_reset;
  logic        start;
  logic [31:0] num_vectors;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [11:0] mem_rd_data;
  logic        mem_rd_valid;
  logic [3:0]  w1, w2, w3;
  logic [3:0]  out_ref, out_eq, out_net;
  logic        busy, done;
  logic [CW-1:0] mismatch_count;
  logic [31:0] first_fail_addr;

  always #5 clk = ~clk;

  vector_replay_checker #(
    .DATA_W(12), .ADDR_W(32), .OUT_W(4), .SETTLE(S), .CNT_W(CW)
  ) dut (
    .clk(clk), .global_reset(global_reset), .start(start),
    .num_vectors(num_vectors), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_rd_valid(mem_rd_valid), .w1(w1), .w2(w2), .w3(w3),
    .out_ref(out_ref), .out_eq(out_eq), .out_net(out_net),
    .busy(busy), .done(done), .mismatch_count(mismatch_count),
    .first_fail_addr(first_fail_addr)
  );

  logic [11:0] mem     [16];
  int          lat_of  [16];
  bit          bad_eq  [16];
  bit          bad_net [16];

  int checks = 0;
  int errors = 0;
  int rem = 0;
  int raddr = 0;
  logic [31:0] rd_q[$];
  logic [3:0] pw1 = 0, pw2 = 0, pw3 = 0;

  function automatic logic [3:0] max3(logic [3:0] a, logic [3:0] b,
                                      logic [3:0] c);
    logic [3:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // three design views: reference plus optionally corrupted copies
  always_comb begin
    out_ref = max3(w1, w2, w3);
    out_eq  = out_ref ^ {3'b0, bad_eq[mem_addr[3:0]]};
    out_net = out_ref ^ {3'b0, bad_net[mem_addr[3:0]]};
  end

  // memory with per-address read latency
  always @(posedge clk) begin
    mem_rd_valid <= 1'b0;
    if (mem_rd_en) begin
      rem   = lat_of[mem_addr[3:0]];
      raddr = int'(mem_addr[3:0]);
      rd_q.push_back(mem_addr);
    end
    if (rem > 0) begin
      rem--;
      if (rem == 0) begin
        mem_rd_valid <= 1'b1;
        mem_rd_data  <= mem[raddr];
      end
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clear_cfg();
    for (int a = 0; a < 16; a++) begin
      mem[a] = '0; lat_of[a] = 1; bad_eq[a] = 0; bad_net[a] = 0;
    end
  endtask

  // start a replay of n vectors, optionally poking start while busy,
  // then compare everything against the transaction-level model
  task automatic do_case(string tag, int n, bit poke);
    int cyc, exp_cyc, nbad, ffa;
    bit seq_ok;
    exp_cyc = 1; nbad = 0; ffa = 0;
    for (int a = 1; a <= n; a++) begin
      exp_cyc += 2 + lat_of[a] + S;
      if (bad_eq[a] || bad_net[a]) begin
        nbad++;
        if (ffa == 0) ffa = a;
      end
    end
    if (n > 0) begin
      pw1 = 4'(mem[n] & 12'hf);
      pw2 = 4'((mem[n] >> 4) & 12'hf);
      pw3 = 4'((mem[n] >> 8) & 12'hf);
    end
    if (nbad > 3) nbad = 3;
    @(negedge clk);
    rd_q.delete();
    start = 1'b1;
    num_vectors = n;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    if (n > 0)
      chk({tag, "_t1"}, {busy, mem_rd_en, mem_addr}, {2'b11, 32'd1});
    while (!done && cyc < 2000) begin
      if (poke) start = (cyc % 3 == 1);
      @(posedge clk);
      #1 cyc++;
    end
    start = 1'b0;
    chk({tag, "_done_cyc"}, cyc, exp_cyc);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_mis"}, mismatch_count, nbad);
    chk({tag, "_ffa"}, first_fail_addr, ffa);
    chk({tag, "_w"}, {w3, w2, w1}, {pw3, pw2, pw1});
    seq_ok = (rd_q.size() == n);
    foreach (rd_q[i]) if (rd_q[i] != i + 1) seq_ok = 0;
    chk({tag, "_addr_seq"}, seq_ok, 1);
    @(posedge clk);
    #1 chk({tag, "_idle_after"}, {busy, done}, 0);
  endtask

  typedef struct {
    logic [11:0] d;
    logic [3:0]  a, b, c;
    bit          bad;
  } vec_t;

  vec_t tab[6];

  initial begin
    tab[0] = '{12'h321, 4'h1, 4'h2, 4'h3, 1'b0};
    tab[1] = '{12'hABC, 4'hC, 4'hB, 4'hA, 1'b0};
    tab[2] = '{12'hF0F, 4'hF, 4'h0, 4'hF, 1'b1};
    tab[3] = '{12'h000, 4'h0, 4'h0, 4'h0, 1'b0};
    tab[4] = '{12'h8E7, 4'h7, 4'hE, 4'h8, 1'b1};
    tab[5] = '{12'hFFF, 4'hF, 4'hF, 4'hF, 1'b0};

    clear_cfg();
    global_reset = 1'b1;
    start = 1'b0;
    num_vectors = '0;
    repeat (3) @(posedge clk);
    #1 chk("reset_state",
           {mem_rd_en, mem_addr, w1, w2, w3, busy, done,
            mismatch_count, first_fail_addr}, 0);
    global_reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      clear_cfg();
      mem[1] = tab[i].d;
      bad_net[1] = tab[i].bad;
      do_case("tab", 1, 0);
      chk("tab_fields", {w1, w2, w3}, {tab[i].a, tab[i].b, tab[i].c});
      chk("tab_fail", mismatch_count, tab[i].bad);
    end

    clear_cfg();
    for (int a = 1; a <= 4; a++) mem[a] = 12'(a * 12'h135);
    bad_net[3] = 1;
    do_case("inject", 4, 0);
    chk("inject_ffa", first_fail_addr, 3);

    do_case("zero", 0, 0);

    clear_cfg();
    for (int a = 1; a <= 3; a++) mem[a] = 12'(12'h9A5 + a);
    lat_of[1] = 1; lat_of[2] = 3; lat_of[3] = 1;
    do_case("varlat", 3, 1);

    clear_cfg();
    for (int a = 1; a <= 3; a++) mem[a] = 12'(12'h417 * a);
    bad_eq[1] = 1;
    @(negedge clk);
    start = 1'b1;
    num_vectors = 3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 chk("rst_pre", {busy, mismatch_count, w1}, {1'b1, 2'd1, mem[2][3:0]});
    global_reset = 1'b1;
    @(posedge clk);
    #1 chk("rst_outputs",
           {mem_rd_en, mem_addr, w1, w2, w3, busy, done,
            mismatch_count, first_fail_addr}, 0);
    global_reset = 1'b0;
    pw1 = 0; pw2 = 0; pw3 = 0;
    do_case("rst_replay", 3, 0);

    clear_cfg();
    for (int a = 1; a <= 5; a++) begin
      mem[a] = 12'(12'h2D1 ^ (a << 3));
      if (a == 1) bad_eq[a] = 1;
      else bad_net[a] = 1;
    end
    do_case("sat", 5, 0);

    for (int it = 0; it < 25; it++) begin
      int n, r;
      clear_cfg();
      n = $urandom_range(0, 6);
      for (int a = 1; a <= n; a++) begin
        mem[a] = 12'($urandom);
        lat_of[a] = $urandom_range(1, 4);
        r = $urandom_range(0, 7);
        bad_eq[a] = (r == 0);
        bad_net[a] = (r == 1);
      end
      do_case("rnd", n, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
